periph_bus_fabric: RTL
======================

// Module: periph_bus_fabric
// PURPOSE
//  Parametrised memory-mapped interconnect between the RV32 data port and N_SLV peripherals
//  (RAM, SW, LED, 7-seg, timer, I2C temp sensor, ...), replacing the fixed single-cycle address decoder.
//  Adds a per-slave ready handshake, a timeout watchdog, unmapped-address detection, and a
//  readable bus-error capture register. Sits between the core's data bus and all slave ports.
// PARAMETERS
//  N_SLV     8                       number of slave windows (1..16)
//  DW        32                      data width
//  AW        32                      address width
//  SLV_BASE  {N_SLV{AW'h0}}          packed N_SLV*AW base addresses; slot k = SLV_BASE[k*AW+:AW]
//  SLV_MASK  {N_SLV{AW'hFFFF_F000}}  packed masks; slot k hits when (addr & mask) == base
//  TIMEOUT   255                     cycles to wait for slave ready before aborting (>=1)
//  ERR_ADDR  32'h0000_2FF0           base of the internal 2-word error block (status, fault address)
// PORTS
//  clk_i      in   1        single clock
//  rst_ni     in   1        synchronous, active-low reset
//  m_addr_i   in   AW       master byte address
//  m_wdata_i  in   DW       master write data
//  m_we_i     in   1        write request (1-cycle strobe)
//  m_re_i     in   1        read request (1-cycle strobe)
//  m_rdata_o  out  DW       read data, valid when m_ready_o=1
//  m_ready_o  out  1        1-cycle completion pulse
//  m_err_o    out  1        1-cycle pulse with m_ready_o when the access failed
//  s_sel_o    out  N_SLV    one-hot slave select, held for the whole access
//  s_we_o     out  1        write qualifier for the selected slave
//  s_addr_o   out  AW       address offset (m_addr_i & ~SLV_MASK[k]), registered
//  s_wdata_o  out  DW       registered write data
//  s_rdata_i  in   N_SLV*DW packed slave read data
//  s_ready_i  in   N_SLV    per-slave completion; combinational-ready slaves tie this to 1
//  irq_err_o  out  1        level; high while the sticky error flag is set
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; timeout counter, error status, and fault address cleared.
//  FSM IDLE -> ACCESS -> RESP -> IDLE.
//   IDLE: on m_we_i|m_re_i, register addr/wdata/we, decode, and go to ACCESS.
//     If both strobes are high, the write wins.
//     Decode rule: the lowest-index matching slot wins. An ERR_ADDR hit is decoded internally
//     and takes priority over the slots.
//   ACCESS: s_sel_o[k]=1, s_we_o=registered we. Counter increments each cycle.
//     s_ready_i[k]=1 -> capture s_rdata_i[k] (reads) -> RESP.
//     Counter reaches TIMEOUT -> abort with err.
//     Unmapped address -> RESP with err next cycle; no slave is selected.
//     Internal ERR block -> RESP next cycle.
//   RESP: m_ready_o=1 for 1 cycle; m_rdata_o valid. s_sel_o/s_we_o drop to 0. Return to IDLE.
//     New strobes arriving in RESP are ignored; the master must wait for m_ready_o.
//  Latency: internal or unmapped access = 3 cycles strobe->ready.
//    Slave ready in the first ACCESS cycle = 3 cycles.
//    Each cycle of ready delay adds 1 cycle.
//  Error capture: on err, status <= {cnt_sat[7:0], code[1:0]} and fault_addr <= address.
//    code: 01 = unmapped, 10 = timeout.
//    cnt is a saturating 8-bit error count (holds at 255).
//    Fault_addr keeps the first fault until status is cleared.
//    Read status @ERR_ADDR; read fault_addr @ERR_ADDR+4.
//    Any write to ERR_ADDR clears status, count, fault_addr, and irq_err_o.
//    If a new error occurs in the same cycle as the clear, the error wins.
//  Failed reads return 32'hDEAD_BEEF. A failed write has no side effect.
//  Reset asserted mid-access: next edge forces IDLE and drops s_sel_o. No m_ready_o is issued.
//  Counter width is clog2(TIMEOUT+1). Counter clears on every entry to ACCESS.
// STRUCTURE
//  Package bus_pkg: state enum {IDLE,ACCESS,RESP}; err code enum; DEADBEEF constant;
//    ERR_ADDR default; default base/mask map for the current SoC.
//    Map: RAM 0x1000/0xFFFF_F000, SW 0x2000, LED 0x2004, SEG 0x2008, TIMER 0x2010, TEMP 0x2020.
//  Sub-module: bus_addr_decode (combinational priority decoder: hit vector -> one-hot + valid),
//    instantiated once.
// TESTING
//  1 Write 0x1234 to slot0 base+0x10, slave ready tied 1 -> s_sel_o=0x01, s_addr_o=0x10,
//    s_wdata_o=0x1234; m_ready_o 3 cycles after strobe; m_err_o=0.
//  2 Read slot2 with ready delayed 5 cycles, rdata=0xA5A5_0001 -> m_ready_o at cycle 8;
//    m_rdata_o=0xA5A5_0001.
//  3 Read 0x0000_9000 (unmapped) -> m_err_o=m_ready_o=1 at cycle 3; rdata=0xDEAD_BEEF;
//    then read ERR_ADDR -> 0x5 (cnt=1, code=01); read ERR_ADDR+4 -> 0x9000; irq_err_o=1.
//  4 TIMEOUT=4, slave never ready -> abort after 4 ACCESS cycles with m_err_o;
//    status code=10, cnt=2; fault_addr keeps the first fault.
//  5 Write ERR_ADDR -> status=0, fault_addr=0, irq_err_o=0.
//    Then 300 unmapped accesses -> count saturates at 255.
//  6 rst_ni low during ACCESS -> next edge s_sel_o=0, FSM IDLE, no m_ready_o;
//    an overlapping-window read returns the lowest-index slot's data.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and the SoC address map for the peripheral bus fabric.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_UNMAPPED = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } err_code_e;

    localparam logic [31:0] DEADBEEF     = 32'hDEAD_BEEF;
    localparam logic [31:0] ERR_ADDR_DEF = 32'h0000_2FF0;

    // Slots 6/7 are spare: a base bit outside the mask can never match.
    localparam int SOC_N_SLV = 8;
    localparam logic [SOC_N_SLV*32-1:0] SOC_SLV_BASE = {
        32'h0000_0001, 32'h0000_0001, 32'h0000_2020, 32'h0000_2010,
        32'h0000_2008, 32'h0000_2004, 32'h0000_2000, 32'h0000_1000
    };
    localparam logic [SOC_N_SLV*32-1:0] SOC_SLV_MASK = {
        32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF0, 32'hFFFF_FFF0,
        32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_F000
    };

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Priority decoder: lowest-index hit wins; valid when any slot hits.
module bus_addr_decode #(
    parameter int N_SLV = 8
) (
    input  logic [N_SLV-1:0] hit_i,
    output logic [N_SLV-1:0] sel_o,
    output logic             valid_o
);

    logic found;

    always_comb begin
        sel_o = '0;
        found = 1'b0;
        for (int k = 0; k < N_SLV; k++) begin
            if (hit_i[k] && !found) begin
                sel_o[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign valid_o = |hit_i;

endmodule

// File: rtl/periph_bus_fabric.sv
// Memory-mapped interconnect: decode, per-slave ready handshake, timeout
// watchdog and a readable error capture block.
module periph_bus_fabric
    import bus_pkg::*;
#(
    parameter int                  N_SLV    = 8,
    parameter int                  DW       = 32,
    parameter int                  AW       = 32,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = {N_SLV{AW'(0)}},
    parameter logic [N_SLV*AW-1:0] SLV_MASK = {N_SLV{AW'(32'hFFFF_F000)}},
    parameter int                  TIMEOUT  = 255,
    parameter logic [AW-1:0]       ERR_ADDR = AW'(ERR_ADDR_DEF)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [AW-1:0]       m_addr_i,
    input  logic [DW-1:0]       m_wdata_i,
    input  logic                m_we_i,
    input  logic                m_re_i,
    output logic [DW-1:0]       m_rdata_o,
    output logic                m_ready_o,
    output logic                m_err_o,
    output logic [N_SLV-1:0]    s_sel_o,
    output logic                s_we_o,
    output logic [AW-1:0]       s_addr_o,
    output logic [DW-1:0]       s_wdata_o,
    input  logic [N_SLV*DW-1:0] s_rdata_i,
    input  logic [N_SLV-1:0]    s_ready_i,
    output logic                irq_err_o
);

    localparam int            CW           = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] ERR_BLK_MASK = ~AW'(7);

    bus_state_e state_q, state_d;

    logic [N_SLV-1:0] hit, dec_sel, sel_q;
    logic             dec_valid, err_hit;
    logic [AW-1:0]    off_d, off_q, addr_q, fault_q;
    logic [DW-1:0]    wdata_q, rdata_q, rdata_d, slv_rdata;
    logic             we_q, int_q, unm_q, err_q, flag_q, slv_rdy;
    logic [CW-1:0]    cnt_q;
    logic [7:0]       ecnt_q;
    err_code_e        code_q, code_d;
    logic             take, fin, err_evt, clr_evt;

    always_comb begin
        hit = '0;
        for (int k = 0; k < N_SLV; k++) begin
            hit[k] = ((m_addr_i & SLV_MASK[k*AW +: AW]) == SLV_BASE[k*AW +: AW]);
        end
    end

    assign err_hit = ((m_addr_i & ERR_BLK_MASK) == ERR_ADDR);

    bus_addr_decode #(.N_SLV(N_SLV)) u_decode (
        .hit_i   (hit),
        .sel_o   (dec_sel),
        .valid_o (dec_valid)
    );

    always_comb begin
        off_d = '0;
        for (int k = 0; k < N_SLV; k++) begin
            if (dec_sel[k]) off_d = m_addr_i & ~SLV_MASK[k*AW +: AW];
        end
    end

    always_comb begin
        slv_rdy   = 1'b0;
        slv_rdata = '0;
        for (int k = 0; k < N_SLV; k++) begin
            if (sel_q[k]) begin
                slv_rdy   = s_ready_i[k];
                slv_rdata = s_rdata_i[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        fin     = 1'b0;
        err_evt = 1'b0;
        clr_evt = 1'b0;
        code_d  = ERR_NONE;
        rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (m_we_i || m_re_i) begin
                    take    = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Resolution order: internal block, unmapped, slave ready, watchdog.
                if (int_q) begin
                    fin     = 1'b1;
                    clr_evt = we_q && !addr_q[2];
                    if (!we_q) rdata_d = addr_q[2] ? DW'(fault_q) : DW'({ecnt_q, code_q});
                end else if (unm_q) begin
                    fin     = 1'b1;
                    err_evt = 1'b1;
                    code_d  = ERR_UNMAPPED;
                    if (!we_q) rdata_d = DW'(DEADBEEF);
                end else if (slv_rdy) begin
                    fin = 1'b1;
                    if (!we_q) rdata_d = slv_rdata;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    fin     = 1'b1;
                    err_evt = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    if (!we_q) rdata_d = DW'(DEADBEEF);
                end
                if (fin) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            wdata_q <= '0;
            off_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            int_q   <= 1'b0;
            unm_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ecnt_q  <= '0;
            code_q  <= ERR_NONE;
            fault_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            if (take) begin
                addr_q  <= m_addr_i;
                wdata_q <= m_wdata_i;
                we_q    <= m_we_i;
                int_q   <= err_hit;
                unm_q   <= !err_hit && !dec_valid;
                sel_q   <= err_hit ? '0 : dec_sel;
                off_q   <= err_hit ? '0 : off_d;
                cnt_q   <= '0;
            end else if (state_q == ACCESS && !fin) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (fin) begin
                rdata_q <= rdata_d;
                err_q   <= err_evt;
            end
            // A fresh error outranks a same-cycle clear.
            if (err_evt) begin
                ecnt_q <= sat_inc8(ecnt_q);
                code_q <= code_d;
                flag_q <= 1'b1;
                if (!flag_q) fault_q <= addr_q;
            end else if (clr_evt) begin
                ecnt_q  <= '0;
                code_q  <= ERR_NONE;
                flag_q  <= 1'b0;
                fault_q <= '0;
            end
        end
    end

    assign m_ready_o = (state_q == RESP);
    assign m_err_o   = (state_q == RESP) && err_q;
    assign m_rdata_o = rdata_q;
    assign s_sel_o   = (state_q == ACCESS) ? sel_q : '0;
    assign s_we_o    = (state_q == ACCESS) && we_q && (|sel_q);
    assign s_addr_o  = off_q;
    assign s_wdata_o = wdata_q;
    assign irq_err_o = flag_q;

endmodule
